drbg_access_scheduler: RTL and testbench
========================================

Name: drbg_access_scheduler

Overview:
- Sequences the shared hash_drbg_sha256 instance and shares its 256-bit output between NUM_REQ scrambler-lane requesters.
- Arbitration is round-robin among lanes.
- Seed advances from drbg_synchronizer (get_next_seed) take priority over lane requests.
- A forced reseed is scheduled after RESEED_INTERVAL generated blocks.
- Sits between drbg_synchronizer, hash_drbg_sha256 and the scrambler lanes; drives next_seed/next_bits exclusively.

Parameters:
- NUM_REQ, 4: number of lane requesters (2..8).
- RESEED_INTERVAL, 64: blocks generated before an internal forced next_seed (1..65535).
- DATA_W, 256: width of random_bits.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset; all state cleared immediately on assertion.
- init_done  in  1  DRBG instantiation complete (init_ready of the DRBG).
- drbg_ready  in  1  DRBG idle; random_bits valid while high.
- random_bits  in  DATA_W  DRBG output block.
- seed_req  in  1  get_next_seed from drbg_synchronizer.
- block_reseed  in  1  block_drbg_reseed from drbg_synchronizer; suppresses all next_seed issue.
- req  in  NUM_REQ  per-lane level request; held high until ack.
- next_seed  out  1  one-cycle pulse to DRBG.
- next_bits  out  1  one-cycle pulse to DRBG.
- ack  out  NUM_REQ  one-hot one-cycle pulse; rdata valid on the same cycle.
- rdata  out  DATA_W  block delivered to the acked lane.
- seed_ack  out  1  one-cycle pulse when a synchronizer-requested reseed completes.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: all outputs 0; state WAIT_INIT; block counter 0; round-robin pointer 0 (lane 0 highest priority).
- FSM states:
  - WAIT_INIT: hold until init_done=1, then go to IDLE.
  - IDLE: requires drbg_ready=1. Priority: (1) seed_req & !block_reseed -> ISSUE_SEED(ext); (2) blk_cnt==RESEED_INTERVAL & !block_reseed -> ISSUE_SEED(int); (3) any req -> ISSUE_BITS for the round-robin winner. If drbg_ready=0, stay in IDLE.
  - ISSUE_SEED: next_seed=1 for one cycle -> WAIT_SEED.
  - ISSUE_BITS: next_bits=1 for one cycle; latch winner index -> WAIT_BITS.
  - WAIT_SEED / WAIT_BITS: ignore drbg_ready in the first cycle (DRBG deassert latency). Then wait for drbg_ready=1.
    - WAIT_SEED completion: clear blk_cnt; pulse seed_ack only if ext.
    - WAIT_BITS completion: register random_bits into rdata; pulse ack[winner]; blk_cnt+1 (saturating at RESEED_INTERVAL); pointer = winner+1 mod NUM_REQ. Go to IDLE.
- Latency: lane req high in idle -> ack 4 cycles minimum (IDLE, ISSUE, WAIT guard, WAIT done+1 reg). The actual value is governed by drbg_ready.
- Lane rules:
  - A lane dropping req before ack is allowed only in IDLE. Once granted, the ack is delivered even if req drops.
  - ack lane never receives two blocks per grant.
  - rdata holds its last value between acks.
- block_reseed=1: seed requests remain pending (no next_seed). Lane service continues even at blk_cnt==RESEED_INTERVAL; counter saturates and does not wrap.
- seed_req and a lane req in the same cycle: seed first; lane served on the next IDLE visit.
- init_done falling in any state: abort to WAIT_INIT with no ack/seed_ack. Outstanding grant is dropped; the lane must keep req.
- reset_n asserted mid-transaction: outputs to 0 asynchronously; no pulse completes.

Optional Feature:
- Macro DRBG_ACCESS_STATS_EN.
- Defined: adds outputs stat_blocks (32, count of acks, wrapping) and stat_stall (32, cycles spent in IDLE with any req high and drbg_ready=0 or seed pending, saturating). Both are cleared by reset_n.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package drbg_sched_pkg:
  - state enum (WAIT_INIT, IDLE, ISSUE_SEED, WAIT_SEED, ISSUE_BITS, WAIT_BITS);
  - reseed source enum (EXT, INT);
  - localparam for the guard cycle count (1).
- Sub-module drbg_rr_arbiter: combinational round-robin picker from req and pointer. Outputs a one-hot grant and an index. Parameterised by NUM_REQ.

Test Plan:
- Reset then init_done=1 at cycle 5, req=4'b0001, DRBG model ready 3 cycles after pulse -> exactly one next_bits pulse, ack=4'b0001 with rdata equal to the model's block, blk_cnt=1.
- req=4'b1111 held, 8 grants -> ack order lanes 0,1,2,3,0,1,2,3; no lane acked twice consecutively.
- seed_req and req=4'b0010 asserted in the same cycle -> next_seed first, seed_ack pulse, then next_bits and ack[1].
- RESEED_INTERVAL=4 with continuous req -> after the 4th ack an internal next_seed, no seed_ack, blk_cnt back to 0, then lane service resumes.
- block_reseed=1 with seed_req=1 and 10 lane requests -> zero next_seed pulses, 10 acks. Drop block_reseed -> a single next_seed within 3 cycles of IDLE.
- reset_n low during WAIT_BITS -> ack stays 0 and all outputs 0 immediately. After release, busy=1 in WAIT_INIT until init_done.

Source files
------------

// File: rtl/drbg_access_scheduler_pkg.sv
// drbg_sched_pkg: shared state/source types and timing constants for the DRBG access scheduler.
package drbg_sched_pkg;

    typedef enum logic [2:0] {
        WAIT_INIT,
        IDLE,
        ISSUE_SEED,
        WAIT_SEED,
        ISSUE_BITS,
        WAIT_BITS
    } state_t;

    typedef enum logic {
        EXT,
        INT
    } src_t;

    localparam int GUARD_CYCLES = 1;

endpackage

// File: rtl/drbg_access_scheduler_if.sv
// drbg_access_scheduler_if: DRBG, synchronizer and lane signals of the DRBG access scheduler.
interface drbg_access_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 256
);
    logic               init_done;
    logic               drbg_ready;
    logic [DATA_W-1:0]  random_bits;
    logic               seed_req;
    logic               block_reseed;
    logic [NUM_REQ-1:0] req;
    logic               next_seed;
    logic               next_bits;
    logic [NUM_REQ-1:0] ack;
    logic [DATA_W-1:0]  rdata;
    logic               seed_ack;
    logic               busy;

    modport master (
        input  init_done, drbg_ready, random_bits, seed_req, block_reseed, req,
        output next_seed, next_bits, ack, rdata, seed_ack, busy
    );

    modport slave (
        output init_done, drbg_ready, random_bits, seed_req, block_reseed, req,
        input  next_seed, next_bits, ack, rdata, seed_ack, busy
    );
endinterface

// File: rtl/drbg_access_scheduler_arbiter.sv
// drbg_rr_arbiter: combinational round-robin picker; lane ptr has highest priority.
module drbg_rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] idx,
    output logic                       valid
);
    localparam int IW = $clog2(NUM_REQ);

    logic [IW-1:0] j;

    assign valid = |req;

    // Walk from the farthest lane back to ptr so the nearest requester wins last.
    always_comb begin
        idx = '0;
        j   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = IW'((int'(ptr) + k) % NUM_REQ);
            if (req[j]) idx = j;
        end
        grant = valid ? NUM_REQ'(1) << idx : '0;
    end

endmodule

// File: rtl/drbg_access_scheduler.sv
// drbg_access_scheduler: shares one hash DRBG between lanes with seed priority and forced reseeds.
// Optional DRBG_ACCESS_STATS_EN adds stat_blocks/stat_stall counters.
module drbg_access_scheduler
    import drbg_sched_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int RESEED_INTERVAL = 64,
    parameter int DATA_W          = 256
) (
    input logic clk,
    input logic reset_n,
    drbg_access_scheduler_if.master bus
`ifdef DRBG_ACCESS_STATS_EN
    ,
    output logic [31:0] stat_blocks,
    output logic [31:0] stat_stall
`endif
);
    localparam int          IW = $clog2(NUM_REQ);
    localparam logic [15:0] RI = 16'(RESEED_INTERVAL);

    state_t             state, state_nx;
    src_t               src, src_nx;
    logic [IW-1:0]      win, win_nx, ptr, ptr_nx, rr_idx;
    logic [NUM_REQ-1:0] win_oh, win_oh_nx, rr_grant, ack_q, ack_nx;
    logic [DATA_W-1:0]  rdata_q;
    logic [15:0]        blk_cnt, blk_nx;
    logic [1:0]         guard, guard_nx;
    logic               rr_valid, seed_ack_q, seed_ack_nx, busy_q, load, ext_pend, int_pend;

    drbg_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req   (bus.req),
        .ptr   (ptr),
        .grant (rr_grant),
        .idx   (rr_idx),
        .valid (rr_valid)
    );

    assign ext_pend      = bus.seed_req & ~bus.block_reseed;
    assign int_pend      = (blk_cnt == RI) & ~bus.block_reseed;
    assign bus.next_seed = (state == ISSUE_SEED) & bus.init_done;
    assign bus.next_bits = (state == ISSUE_BITS) & bus.init_done;
    assign bus.ack       = ack_q;
    assign bus.rdata     = rdata_q;
    assign bus.seed_ack  = seed_ack_q;
    assign bus.busy      = busy_q;

    // The DRBG drops drbg_ready a cycle after the pulse, so the first wait cycle is ignored.
    always_comb begin
        state_nx    = state;
        src_nx      = src;
        win_nx      = win;
        win_oh_nx   = win_oh;
        ptr_nx      = ptr;
        blk_nx      = blk_cnt;
        guard_nx    = guard == '0 ? guard : guard - 2'd1;
        ack_nx      = '0;
        seed_ack_nx = 1'b0;
        load        = 1'b0;
        if (!bus.init_done) state_nx = WAIT_INIT;
        else case (state)
            WAIT_INIT: state_nx = IDLE;
            IDLE: if (bus.drbg_ready) begin
                if (ext_pend) begin
                    state_nx = ISSUE_SEED;
                    src_nx   = EXT;
                end else if (int_pend) begin
                    state_nx = ISSUE_SEED;
                    src_nx   = INT;
                end else if (rr_valid) begin
                    state_nx  = ISSUE_BITS;
                    win_nx    = rr_idx;
                    win_oh_nx = rr_grant;
                end
            end
            ISSUE_SEED: begin
                state_nx = WAIT_SEED;
                guard_nx = 2'(GUARD_CYCLES);
            end
            ISSUE_BITS: begin
                state_nx = WAIT_BITS;
                guard_nx = 2'(GUARD_CYCLES);
            end
            WAIT_SEED: if (guard == '0 && bus.drbg_ready) begin
                state_nx    = IDLE;
                blk_nx      = '0;
                seed_ack_nx = src == EXT;
            end
            WAIT_BITS: if (guard == '0 && bus.drbg_ready) begin
                state_nx = IDLE;
                load     = 1'b1;
                ack_nx   = win_oh;
                blk_nx   = blk_cnt == RI ? blk_cnt : blk_cnt + 16'd1;
                ptr_nx   = win == IW'(NUM_REQ - 1) ? '0 : win + IW'(1);
            end
            default: state_nx = WAIT_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= WAIT_INIT;
            src        <= EXT;
            win        <= '0;
            win_oh     <= '0;
            ptr        <= '0;
            blk_cnt    <= '0;
            guard      <= '0;
            ack_q      <= '0;
            seed_ack_q <= 1'b0;
            rdata_q    <= '0;
            busy_q     <= 1'b0;
        end else begin
            state      <= state_nx;
            src        <= src_nx;
            win        <= win_nx;
            win_oh     <= win_oh_nx;
            ptr        <= ptr_nx;
            blk_cnt    <= blk_nx;
            guard      <= guard_nx;
            ack_q      <= ack_nx;
            seed_ack_q <= seed_ack_nx;
            rdata_q    <= load ? bus.random_bits : rdata_q;
            busy_q     <= state_nx != IDLE;
        end
    end

`ifdef DRBG_ACCESS_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_blocks <= '0;
            stat_stall  <= '0;
        end else begin
            stat_blocks <= stat_blocks + 32'(|ack_nx);
            stat_stall  <= (state == IDLE && |bus.req && (!bus.drbg_ready || ext_pend || int_pend)
                            && stat_stall != '1) ? stat_stall + 32'd1 : stat_stall;
        end
    end
`endif

endmodule

// File: tb/tb_drbg_access_scheduler.sv
// tb_drbg_access_scheduler: scoreboard bench with a DRBG model that is ready 3 cycles after each pulse.
module tb_drbg_access_scheduler;
    localparam int N  = 4;
    localparam int W  = 256;
    localparam int RI = 4;
    localparam int NS = 0;
    localparam int SA = 1;
    localparam int AK = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    drbg_access_scheduler_if #(.NUM_REQ(N), .DATA_W(W)) bus ();

`ifdef DRBG_ACCESS_STATS_EN
    logic [31:0] stat_blocks, stat_stall;
`endif

    drbg_access_scheduler #(.NUM_REQ(N), .RESEED_INTERVAL(RI), .DATA_W(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
`ifdef DRBG_ACCESS_STATS_EN
        ,
        .stat_blocks (stat_blocks),
        .stat_stall  (stat_stall)
`endif
    );

    function automatic logic [W-1:0] blk(int id);
        return {8{32'(id) ^ 32'hA5A5_0000}};
    endfunction

    // DRBG model: block id k is produced by the k-th next_bits pulse.
    logic         m_ready = 1'b1;
    logic [W-1:0] m_bits  = '0;
    int           m_cnt   = 0;
    int           m_id    = 0;
    assign bus.drbg_ready  = m_ready;
    assign bus.random_bits = m_bits;

    always @(posedge clk) begin
        #1;
        if (bus.next_bits || bus.next_seed) begin
            m_ready = 1'b0;
            m_cnt   = 3;
            if (bus.next_bits) begin
                m_id++;
                m_bits = blk(m_id);
            end
        end else if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) m_ready = 1'b1;
        end
    end

    int           ek_q[$];
    logic [N-1:0] ea_q[$];
    int           ei_q[$];
    string        cn_q[$];
    logic [W-1:0] ca_q[$];
    logic [W-1:0] ce_q[$];
    int vectors = 0;
    int miscompares = 0;
    int ns_cnt = 0;
    int nb_cnt = 0;

    task automatic expect_ev(int k, int lane, int id);
        ek_q.push_back(k);
        ea_q.push_back(k == AK ? N'(1) << lane : N'(0));
        ei_q.push_back(id);
    endtask

    task automatic probe(string n, logic [W-1:0] a, logic [W-1:0] e);
        cn_q.push_back(n);
        ca_q.push_back(a);
        ce_q.push_back(e);
    endtask

    task automatic cmp(string n, logic [W-1:0] a, logic [W-1:0] e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", n, a, e);
        end
    endtask

    task automatic observe(int k);
        if (ek_q.size() == 0) cmp("unexpected_event", W'(k), W'(9));
        else begin
            int           ek = ek_q.pop_front();
            logic [N-1:0] ea = ea_q.pop_front();
            int           ei = ei_q.pop_front();
            cmp("event_kind", W'(k), W'(ek));
            if (k == AK && ek == AK) begin
                cmp("ack", W'(bus.ack), W'(ea));
                cmp("rdata", bus.rdata, blk(ei));
            end
        end
    endtask

    always @(negedge clk) begin
        while (cn_q.size() > 0) cmp(cn_q.pop_front(), ca_q.pop_front(), ce_q.pop_front());
        if (reset_n) begin
            if (bus.next_seed) begin
                ns_cnt++;
                observe(NS);
            end
            if (bus.next_bits) nb_cnt++;
            if (bus.seed_ack) observe(SA);
            if (|bus.ack) observe(AK);
        end
    end

    int left[N];

    task automatic run(int c0, int c1, int c2, int c3, int budget);
        left = '{c0, c1, c2, c3};
        for (int i = 0; i < N; i++) bus.req[i] = left[i] != 0;
        for (int cyc = 0; ; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) if (bus.ack[i] && left[i] > 0) left[i]--;
            for (int i = 0; i < N; i++) bus.req[i] = left[i] != 0;
            if (bus.seed_ack) bus.seed_req = 1'b0;
            #1;
            if (left.sum() == 0 && ek_q.size() == 0) break;
            if (cyc >= budget) begin
                probe("run_timeout", W'(cyc), W'(0));
                break;
            end
        end
    endtask

    initial begin
        int ns0, nb0, k;
        bus.init_done    = 1'b0;
        bus.seed_req     = 1'b0;
        bus.block_reseed = 1'b0;
        bus.req          = '0;
        repeat (2) @(negedge clk);
        probe("reset_ack", W'(bus.ack), W'(0));
        probe("reset_rdata", bus.rdata, W'(0));
        probe("reset_pulses", W'({bus.next_seed, bus.next_bits, bus.seed_ack}), W'(0));
        probe("reset_busy", W'(bus.busy), W'(0));
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        #1 probe("busy_wait_init", W'(bus.busy), W'(1));
        @(negedge clk);
        bus.init_done = 1'b1;

        expect_ev(AK, 0, 1);
        run(1, 0, 0, 0, 40);
        probe("bits_pulses", W'(nb_cnt), W'(1));
        repeat (3) @(negedge clk);
        #1 probe("rdata_hold", bus.rdata, blk(1));

        bus.seed_req = 1'b1;
        expect_ev(NS, 0, 0);
        expect_ev(SA, 0, 0);
        expect_ev(AK, 1, 2);
        run(0, 1, 0, 0, 60);

        expect_ev(AK, 3, 3);
        run(0, 0, 0, 1, 40);

        expect_ev(AK, 0, 4);
        expect_ev(AK, 1, 5);
        expect_ev(NS, 0, 0);
        expect_ev(AK, 2, 6);
        expect_ev(AK, 3, 7);
        expect_ev(AK, 0, 8);
        expect_ev(AK, 1, 9);
        expect_ev(NS, 0, 0);
        expect_ev(AK, 2, 10);
        expect_ev(AK, 3, 11);
        run(2, 2, 2, 2, 300);

        ns0 = ns_cnt;
        bus.block_reseed = 1'b1;
        bus.seed_req     = 1'b1;
        for (int i = 0; i < 10; i++) expect_ev(AK, i % N, 12 + i);
        run(3, 3, 2, 2, 400);
        probe("blocked_seed_pulses", W'(ns_cnt - ns0), W'(0));
        expect_ev(NS, 0, 0);
        expect_ev(SA, 0, 0);
        bus.block_reseed = 1'b0;
        k = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            #1;
            if (ns_cnt != ns0) begin
                k = c;
                break;
            end
        end
        probe("seed_after_unblock", W'(k >= 1 && k <= 3), W'(1));
        run(0, 0, 0, 0, 40);

        nb0 = nb_cnt;
        bus.req = 4'b0100;
        k = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            #1;
            if (nb_cnt != nb0) begin
                k = c;
                break;
            end
        end
        probe("lane2_issue", W'(k != 0), W'(1));
        @(negedge clk);
        reset_n          = 1'b0;
        bus.req          = '0;
        bus.init_done    = 1'b0;
        #1;
        probe("abort_ack", W'(bus.ack), W'(0));
        probe("abort_pulses", W'({bus.next_seed, bus.next_bits, bus.seed_ack}), W'(0));
        probe("abort_busy", W'(bus.busy), W'(0));
        probe("abort_rdata", bus.rdata, W'(0));
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        #1 probe("busy_after_reset", W'(bus.busy), W'(1));
        bus.init_done = 1'b1;
        repeat (4) @(negedge clk);
        #1 probe("busy_idle", W'(bus.busy), W'(0));
        probe("pending_events", W'(ek_q.size()), W'(0));
        repeat (2) @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
